serial_divider: RTL and testbench

SERIAL_DIVIDER -- requirements
Module: serial_divider

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 30 +++
 rtl/serial_divider.sv | 143 ++++++++++++++
 tb/tb_serial_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the serial restoring divider: default width,
// RV32M divide op encodings and the controller state encoding.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } div_state_e;

    // op[0] clear selects the signed variants, op[1] set selects remainder.
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor in XLEN+1 bits, keep the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, divisor};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/serial_divider.sv
// Iterative RV32M divider: XLEN restoring steps on magnitudes, sign fix-up
// on the final step, one-cycle fast path for divide-by-zero and overflow.
//
// state  | meaning
// S_IDLE | waiting for start, operands not yet captured
// S_CALC | one restoring step per cycle, counter 0..XLEN-1
// S_FIN  | done pulse, result register valid
module serial_divider
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q, result_q;
    logic             rem_sel_q, neg_quo_q, neg_rem_q;

    logic             is_signed, a_neg, b_neg, div_zero, sgn_ovf, fast;
    logic [XLEN-1:0]  a_abs, b_abs, fast_result;
    logic [XLEN-1:0]  step_rem, step_quo, quo_fix, rem_fix;

    // Operand conditioning and special-case detection, used only at accept.
    always_comb begin
        is_signed = op_is_signed(op);
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor : divisor;
        div_zero  = (divisor == '0);
        sgn_ovf   = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor == '1);
        fast      = div_zero | sgn_ovf;
        if (div_zero) begin
            fast_result = op_is_rem(op) ? dividend : '1;
        end else begin
            fast_result = op_is_rem(op) ? '0 : dividend;
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        quo_fix = neg_quo_q ? -step_quo : step_quo;
        rem_fix = neg_rem_q ? -step_rem : step_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = fast ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q     <= '0;
                        rem_q     <= '0;
                        quo_q     <= a_abs;
                        dvs_q     <= b_abs;
                        rem_sel_q <= op_is_rem(op);
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (fast) begin
                            result_q <= fast_result;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        result_q <= rem_sel_q ? rem_fix : quo_fix;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FIN);
    end

    assign result = result_q;

endmodule

// File: tb/tb_serial_divider.sv
// Scoreboard bench for serial_divider: reference results from native SV
// division are queued at issue and compared when done pulses.
module tb_serial_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    serial_divider #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        if (b == 32'd0) begin
            r = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = o[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (o)
                2'b00:   r = $signed(a) / $signed(b);
                2'b01:   r = a / b;
                2'b10:   r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        logic [31:0] exp_res;
        int exp_lat;
        int k;
        int extra;
        bit busy_ok;
        bit got;
        exp_q.push_back(model(o, a, b));
        exp_lat = model_lat(o, a, b);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        k = 1;
        busy_ok = 1'b1;
        got = 1'b0;
        while (k <= 40 && !got) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (disturb && k == 10) begin
                    start    = 1'b1;
                    op       = 2'b01;
                    dividend = $urandom;
                    divisor  = $urandom_range(1, 50);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        exp_res = exp_q.pop_front();
        chk("latency", got ? 32'(k) : 32'd0, 32'(exp_lat));
        chk("busy_while_running", 32'(busy_ok), 32'd1);
        chk("result", result, exp_res);
        @(negedge clk);
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("result_hold", result, exp_res);
        if (disturb) begin
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("extra_done_count", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        do_div(2'b01, 32'd100, 32'd7, 1'b0);
        do_div(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_div(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_div(2'b00, 32'd5, 32'd0, 1'b0);
        do_div(2'b11, 32'd5, 32'd0, 1'b0);
        do_div(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
        do_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(2'b01, 32'd1000, 32'd10, 1'b1);
        do_div(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(2'b00, 32'h8000_0000, 32'd1, 1'b0);
        do_div(2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        do_div(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // Abort mid-calculation with start held high alongside reset.
        @(negedge clk);
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        do_div(2'b01, 32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            do_div(ro, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
